// File: rtl/mem_arb_pkg.sv
// Shared widths, requester id type and the round-robin pick used by the
// two-requester memory front end.
package mem_arb_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int NUM_REQ        = 2;
  localparam int MEM_RD_LAT     = 1;

  typedef logic req_id_t;

  // Single eligible requester wins outright; on contention the pointer decides.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input req_id_t            ptr);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (&elig) g[ptr] = 1'b1;
    else       g = elig;
    return g;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response/memory bundle between the two clients, the arbiter and
// the single-port memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = mem_arb_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_arb_pkg::DEF_DATA_WIDTH
) ();
  localparam int NR = mem_arb_pkg::NUM_REQ;

  logic [NR-1:0]                 req_valid;
  logic [NR-1:0]                 req_ready;
  logic [NR-1:0]                 req_we;
  logic [NR-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NR-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NR-1:0]                 rsp_valid;
  logic [NR-1:0]                 rsp_ready;
  logic [NR-1:0][DATA_WIDTH-1:0] rsp_rdata;
  logic                          mem_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_valid;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rsp_slot.sv
// One-entry read response buffer; full while rsp_valid is high, holds data
// stable until the requester takes it.
module mem_rsp_slot #(
  parameter int DATA_WIDTH = mem_arb_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end sharing one single-port memory between two
// requesters; read data is steered back through per-requester slots.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  logic [NUM_REQ-1:0]                 elig, grant, slot_load;
  logic [NUM_REQ-1:0]                 rsp_valid_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_rdata_q;
  logic                               granted, rd_grant, rd_pend;
  req_id_t                            rr_ptr, rd_id, win_id;
  logic                               en_d;
  logic [ADDR_WIDTH-1:0]              addr_d;
  logic [DATA_WIDTH-1:0]              wdata_d;

  // A read needs a free path back: nothing of its own in flight or buffered.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = bus.req_valid[i] &
                (bus.req_we[i] | (~(rd_pend & (rd_id == req_id_t'(i))) & ~rsp_valid_q[i]));
  end

  always_comb begin
    grant    = rst ? '0 : rr_pick(elig, rr_ptr);
    granted  = |grant;
    win_id   = grant[1];
    rd_grant = granted & ~bus.req_we[win_id];
    en_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    if (granted) begin
      en_d    = bus.req_we[win_id];
      addr_d  = bus.req_addr[win_id];
      wdata_d = bus.req_wdata[win_id];
    end
  end

  assign bus.req_ready = grant;
  assign bus.mem_en    = en_d;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= 1'b0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      if (granted)  rr_ptr <= ~win_id;
      rd_pend <= rd_grant;
      if (rd_grant) rd_id  <= win_id;
    end
  end

  // Memory output is valid exactly one cycle after issue; capture it then.
  always_comb begin
    slot_load = '0;
    for (int i = 0; i < NUM_REQ; i++)
      slot_load[i] = rd_pend & (rd_id == req_id_t'(i));
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    mem_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[g]),
      .load_data (bus.mem_rdata),
      .rsp_valid (rsp_valid_q[g]),
      .rsp_ready (bus.rsp_ready[g]),
      .rsp_rdata (rsp_rdata_q[g])
    );
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  a_rd_valid: assert property (@(posedge clk) disable iff (rst) rd_pend |-> bus.mem_valid);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory: write array on EN, registered read, Valid_out high every live cycle.
  logic [DW-1:0] mem_q [1<<AW];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < (1<<AW); k++) mem_q[k] <= '0;
      bus.mem_rdata <= '0;
      bus.mem_valid <= 1'b0;
    end else begin
      if (bus.mem_en) mem_q[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem_q[bus.mem_addr];
      bus.mem_valid <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_reqs;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = we;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_reqs;
    bus.rsp_ready = '0;
    drive(0, 1'b1, 4'd3, 32'h1);
    drive(1, 1'b1, 4'd2, 32'h2);
    tick;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mem_en",    64'(bus.mem_en), 64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    tick;
    idle_reqs;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;

    // single write then read
    drive(0, 1'b1, 4'd3, 32'hDEADBEEF);
    settle;
    chk("wr_ready", 64'(bus.req_ready), 64'd1);
    chk("wr_mem_en", 64'(bus.mem_en), 64'd1);
    chk("wr_mem_addr", 64'(bus.mem_addr), 64'd3);
    chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    tick;
    drive(0, 1'b0, 4'd3, 32'h0);
    settle;
    chk("rd_ready", 64'(bus.req_ready), 64'd1);
    chk("rd_mem_en", 64'(bus.mem_en), 64'd0);
    tick;
    idle_reqs;
    settle;
    chk("rd_t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick;
    chk("rd_t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rd_t2_rdata0", 64'(bus.rsp_rdata[0]), 64'hDEADBEEF);
    tick;
    chk("rd_t3_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // round-robin contention on writes
    do_reset;
    drive(0, 1'b1, 4'd1, 32'h100);
    drive(1, 1'b1, 4'd2, 32'h200);
    for (int k = 0; k < 6; k++) begin
      settle;
      chk($sformatf("rr_grant_%0d", k), 64'(bus.req_ready), (k % 2) ? 64'd2 : 64'd1);
      chk($sformatf("rr_addr_%0d", k), 64'(bus.mem_addr), (k % 2) ? 64'd2 : 64'd1);
      tick;
    end
    idle_reqs;

    // backpressure on requester 1
    bus.rsp_ready[1] = 1'b0;
    drive(1, 1'b1, 4'd5, 32'h12345678);
    settle;
    chk("bp_wr5_ready", 64'(bus.req_ready), 64'd2);
    tick;
    drive(0, 1'b1, 4'd9, 32'h99);
    drive(1, 1'b0, 4'd5, 32'h0);
    settle;
    chk("bp_c0_ready", 64'(bus.req_ready), 64'd1);
    tick;
    settle;
    chk("bp_c1_ready", 64'(bus.req_ready), 64'd2);
    tick;
    settle;
    chk("bp_c2_ready", 64'(bus.req_ready), 64'd1);
    tick;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk($sformatf("bp_hold_valid_%0d", k), 64'(bus.rsp_valid[1]), 64'd1);
      chk($sformatf("bp_hold_rdata_%0d", k), 64'(bus.rsp_rdata[1]), 64'h12345678);
      chk($sformatf("bp_hold_ready_%0d", k), 64'(bus.req_ready), 64'd1);
      tick;
    end
    bus.rsp_ready[1] = 1'b1;
    settle;
    chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
    tick;
    settle;
    chk("bp_next_rd_ready", 64'(bus.req_ready), 64'd2);
    tick;
    idle_reqs;
    tick;
    chk("bp_next_rsp_valid", 64'(bus.rsp_valid[1]), 64'd1);
    chk("bp_next_rdata", 64'(bus.rsp_rdata[1]), 64'h12345678);
    tick;

    // write then read of the same address in the following cycle
    do_reset;
    drive(0, 1'b1, 4'd7, 32'hA5A5A5A5);
    settle;
    chk("wri_wr_ready", 64'(bus.req_ready), 64'd1);
    tick;
    idle_reqs;
    drive(1, 1'b0, 4'd7, 32'h0);
    settle;
    chk("wri_rd_ready", 64'(bus.req_ready), 64'd2);
    tick;
    idle_reqs;
    tick;
    chk("wri_rsp_valid", 64'(bus.rsp_valid), 64'd2);
    chk("wri_rdata", 64'(bus.rsp_rdata[1]), 64'hA5A5A5A5);
    tick;

    // read wins arbitration over a same-address write: old data returned
    drive(0, 1'b1, 4'd0, 32'h1111);
    settle;
    chk("same_pre_ready", 64'(bus.req_ready), 64'd1);
    tick;
    idle_reqs;
    drive(0, 1'b1, 4'd6, 32'h5A5A5A5A);
    drive(1, 1'b0, 4'd6, 32'h0);
    settle;
    chk("same_rd_wins", 64'(bus.req_ready), 64'd2);
    tick;
    bus.req_valid[1] = 1'b0;
    settle;
    chk("same_wr_next", 64'(bus.req_ready), 64'd1);
    tick;
    idle_reqs;
    chk("same_rsp_valid", 64'(bus.rsp_valid), 64'd2);
    chk("same_old_rdata", 64'(bus.rsp_rdata[1]), 64'd0);
    tick;
    drive(1, 1'b0, 4'd6, 32'h0);
    settle;
    chk("same_reread_ready", 64'(bus.req_ready), 64'd2);
    tick;
    idle_reqs;
    tick;
    chk("same_new_rdata", 64'(bus.rsp_rdata[1]), 64'h5A5A5A5A);
    tick;

    // reset in the cycle after a read handshake
    drive(0, 1'b0, 4'd11, 32'h0);
    settle;
    chk("mid_rd_ready", 64'(bus.req_ready), 64'd1);
    tick;
    rst = 1'b1;
    settle;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick;
    idle_reqs;
    rst = 1'b0;
    tick;
    chk("mid_after_rsp_valid_a", 64'(bus.rsp_valid), 64'd0);
    tick;
    chk("mid_after_rsp_valid_b", 64'(bus.rsp_valid), 64'd0);
    drive(0, 1'b0, 4'd11, 32'h0);
    drive(1, 1'b0, 4'd12, 32'h0);
    settle;
    chk("mid_ptr_zero", 64'(bus.req_ready), 64'd1);
    tick;
    bus.req_valid[0] = 1'b0;
    settle;
    chk("mid_req1_next", 64'(bus.req_ready), 64'd2);
    tick;
    idle_reqs;
    chk("mid_rsp0_valid", 64'(bus.rsp_valid), 64'd1);
    chk("mid_rsp0_rdata", 64'(bus.rsp_rdata[0]), 64'd0);
    tick;
    chk("mid_rsp1_valid", 64'(bus.rsp_valid), 64'd2);
    tick;

    // idle: memory reports valid but nothing reaches the requesters
    for (int k = 0; k < 3; k++) begin
      settle;
      chk($sformatf("idle_mem_en_%0d", k), 64'(bus.mem_en), 64'd0);
      chk($sformatf("idle_mem_addr_%0d", k), 64'(bus.mem_addr), 64'd0);
      chk($sformatf("idle_mem_valid_%0d", k), 64'(bus.mem_valid), 64'd1);
      chk($sformatf("idle_rsp_valid_%0d", k), 64'(bus.rsp_valid), 64'd0);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
